// File: rtl/fusion_issue_ctrl.sv
// fusion_issue_ctrl: two-entry window between fetch and the fusion decoder.
// It pairs LUI+ADDI, AUIPC+JALR and LOAD+ALU and issues one payload per handshake.
//
// Ports:
//   clk, rst        core clock and asynchronous active-low reset
//   in_valid/ready  fetch handshake; in_instr and in_pc are the offered entry
//   flush           synchronous redirect that empties the window
//   out_valid/ready issue handshake towards decode
//   out_instr0/1    head and partner (partner is zero when the payload is single)
//   out_pc          PC of the head
//   fuse_flag/type  fused-pair marker: 00 none, 01 LUI+ADDI, 10 AUIPC+JALR, 11 LOAD+ALU
//   fused_cnt       saturating count of fused issues
module fusion_issue_ctrl #(
  parameter int unsigned WAIT_MAX = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr0,
  output logic [31:0]      out_instr1,
  output logic [31:0]      out_pc,
  output logic             fuse_flag,
  output logic [1:0]       fuse_type,
  output logic [CNT_W-1:0] fused_cnt
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_MAX - 1);
  localparam logic [3:0] WAIT_TOP  = 4'(WAIT_MAX);

  typedef enum logic [1:0] {
    EMPTY,
    GATHER,
    OFFER
  } state_t;

  state_t      state;
  logic [1:0]  count;
  logic [3:0]  wait_cnt;
  logic        lock;
  logic [1:0]  dec_type;
  logic [31:0] s0_instr;
  logic [31:0] s0_pc;
  logic [31:0] s1_instr;
  logic [31:0] s1_pc;

  logic push;
  logic pop;
  logic fused;

  function automatic logic is_head(
    input logic [31:0] i
  );
    return (i[6:0] == OP_LUI)
        || (i[6:0] == OP_AUIPC)
        || (i[6:0] == OP_LOAD);
  endfunction

  function automatic logic [1:0] pair_type(
    input logic [31:0] i0,
    input logic [31:0] p0,
    input logic [31:0] i1,
    input logic [31:0] p1
  );
    logic [4:0] rd0;
    logic       link;
    logic       f3z;
    logic [1:0] t;
    rd0  = i0[11:7];
    link = (p1 == p0 + 32'd4) && (rd0 != 5'd0);
    f3z  = (i1[14:12] == 3'b000);
    t    = 2'b00;
    unique case (1'b1)
      i0[6:0] == OP_LUI: begin
        if (link && i1[6:0] == OP_IMM && f3z
            && i1[19:15] == rd0 && i1[11:7] == rd0)
          t = 2'b01;
      end
      i0[6:0] == OP_AUIPC: begin
        if (link && i1[6:0] == OP_JALR && f3z
            && i1[19:15] == rd0)
          t = 2'b10;
      end
      i0[6:0] == OP_LOAD: begin
        if (link && i1[6:0] == OP_ALU
            && (i1[19:15] == rd0 || i1[24:20] == rd0))
          t = 2'b11;
      end
      default: t = 2'b00;
    endcase
    return t;
  endfunction

  assign in_ready  = (count < 2'd2);
  assign push      = in_valid && in_ready;
  assign out_valid = (state == OFFER);
  assign pop       = out_valid && out_ready;
  assign fused     = !lock && (count == 2'd2)
                  && (dec_type != 2'b00);

  assign out_instr0 = out_valid ? s0_instr : '0;
  assign out_pc     = out_valid ? s0_pc : '0;
  assign out_instr1 = fused_out() ? s1_instr : '0;
  assign fuse_flag  = fused_out();
  assign fuse_type  = fused_out() ? dec_type : 2'b00;

  function automatic logic fused_out();
    return out_valid && fused;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= EMPTY;
      count     <= 2'd0;
      wait_cnt  <= 4'd0;
      lock      <= 1'b0;
      dec_type  <= 2'b00;
      s0_instr  <= '0;
      s0_pc     <= '0;
      s1_instr  <= '0;
      s1_pc     <= '0;
      fused_cnt <= '0;
    end else if (flush) begin
      state    <= EMPTY;
      count    <= 2'd0;
      wait_cnt <= 4'd0;
      lock     <= 1'b0;
      dec_type <= 2'b00;
    end else begin
      if (pop && fused && fused_cnt != '1)
        fused_cnt <= fused_cnt + 1'b1;
      unique case (state)
        EMPTY: begin
          if (push) begin
            s0_instr <= in_instr;
            s0_pc    <= in_pc;
            count    <= 2'd1;
            wait_cnt <= 4'd0;
            dec_type <= 2'b00;
            state    <= is_head(in_instr) ? GATHER : OFFER;
          end
        end
        GATHER: begin
          if (push) begin
            s1_instr <= in_instr;
            s1_pc    <= in_pc;
            count    <= 2'd2;
            dec_type <= lock ? 2'b00
                      : pair_type(s0_instr, s0_pc,
                                  in_instr, in_pc);
            state    <= OFFER;
          end else if (wait_cnt == WAIT_LAST) begin
            // partner never showed up: commit to a single
            wait_cnt <= WAIT_TOP;
            lock     <= 1'b1;
            dec_type <= 2'b00;
            state    <= OFFER;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        OFFER: begin
          if (pop) begin
            lock     <= 1'b0;
            wait_cnt <= 4'd0;
            dec_type <= 2'b00;
            if (fused) begin
              count <= 2'd0;
              state <= EMPTY;
            end else if (count == 2'd2) begin
              s0_instr <= s1_instr;
              s0_pc    <= s1_pc;
              count    <= 2'd1;
              state    <= is_head(s1_instr) ? GATHER : OFFER;
            end else if (push) begin
              s0_instr <= in_instr;
              s0_pc    <= in_pc;
              count    <= 2'd1;
              state    <= is_head(in_instr) ? GATHER : OFFER;
            end else begin
              count <= 2'd0;
              state <= EMPTY;
            end
          end else if (push) begin
            // decision register is untouched, so the payload stays stable
            s1_instr <= in_instr;
            s1_pc    <= in_pc;
            count    <= 2'd2;
          end
        end
        default: begin
          state <= EMPTY;
          count <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fusion_issue_ctrl.sv
// tb_fusion_issue_ctrl: directed scenarios plus randomized traffic
// compared against a queue-based model of the issue window.
module tb_fusion_issue_ctrl;

  localparam int WAIT_MAX = 2;
  localparam int CNT_W    = 3;
  localparam int MAXC     = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [31:0]      in_pc;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr0;
  logic [31:0]      out_instr1;
  logic [31:0]      out_pc;
  logic             fuse_flag;
  logic [1:0]       fuse_type;
  logic [CNT_W-1:0] fused_cnt;

  int checks;
  int failures;

  fusion_issue_ctrl #(
    .WAIT_MAX(WAIT_MAX),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_instr(in_instr),
    .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr0(out_instr0),
    .out_instr1(out_instr1),
    .out_pc(out_pc),
    .fuse_flag(fuse_flag),
    .fuse_type(fuse_type),
    .fused_cnt(fused_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [63:0] m_win[$];
  bit          m_commit;
  logic [1:0]  m_dec;
  int          m_age;
  int          m_cnt;
  logic [31:0] m_last_pc;

  function automatic bit m_cand(input logic [31:0] i);
    return i[6:0] == 7'h37 || i[6:0] == 7'h17 || i[6:0] == 7'h03;
  endfunction

  function automatic logic [1:0] m_pair(input logic [63:0] a,
                                        input logic [63:0] b);
    logic [31:0] ia, ib;
    int rd, brs1, brs2, brd, f3;
    bit ok;
    ia = a[31:0];
    ib = b[31:0];
    rd = int'(ia[11:7]);
    brd = int'(ib[11:7]);
    brs1 = int'(ib[19:15]);
    brs2 = int'(ib[24:20]);
    f3 = int'(ib[14:12]);
    ok = (b[63:32] - a[63:32] == 32'd4) && rd != 0;
    if (!ok) return 2'b00;
    if (ia[6:0] == 7'h37 && ib[6:0] == 7'h13 && f3 == 0
        && brs1 == rd && brd == rd) return 2'b01;
    if (ia[6:0] == 7'h17 && ib[6:0] == 7'h67 && f3 == 0
        && brs1 == rd) return 2'b10;
    if (ia[6:0] == 7'h03 && ib[6:0] == 7'h33
        && (brs1 == rd || brs2 == rd)) return 2'b11;
    return 2'b00;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_win.delete();
      m_commit = 0;
      m_dec = 2'b00;
      m_age = 0;
      m_cnt = 0;
      m_last_pc = 32'h1000;
    end else if (flush) begin
      m_win.delete();
      m_commit = 0;
      m_dec = 2'b00;
      m_age = 0;
    end else begin
      bit pop_now, push_now, fresh;
      logic [63:0] tmp;
      pop_now = m_commit && out_ready;
      push_now = in_valid && m_win.size() < 2;
      fresh = 0;
      if (pop_now) begin
        tmp = m_win.pop_front();
        if (m_dec != 2'b00) begin
          tmp = m_win.pop_front();
          if (m_cnt != MAXC) m_cnt++;
        end
        m_commit = 0;
        m_dec = 2'b00;
        m_age = 0;
        fresh = 1;
      end
      if (push_now) begin
        if (m_win.size() == 0) fresh = 1;
        m_win.push_back({in_pc, in_instr});
        m_last_pc = in_pc;
      end
      if (!m_commit && m_win.size() > 0) begin
        if (m_win.size() == 2) begin
          m_commit = 1;
          m_dec = m_pair(m_win[0], m_win[1]);
        end else if (!m_cand(m_win[0][31:0])) begin
          m_commit = 1;
          m_dec = 2'b00;
        end else if (!fresh) begin
          m_age++;
          if (m_age >= WAIT_MAX) begin
            m_commit = 1;
            m_dec = 2'b00;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    in_instr = '0;
    in_pc = '0;
    flush = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic drive(input logic v, input logic [31:0] i,
                       input logic [31:0] p);
    in_valid = v;
    in_instr = i;
    in_pc = p;
    @(negedge clk);
  endtask

  function automatic logic [31:0] gen_instr();
    logic [4:0] rd, rs1, rs2;
    logic [11:0] imm;
    logic [19:0] u;
    logic [2:0] f3;
    rd = 5'($urandom_range(0, 3));
    rs1 = 5'($urandom_range(0, 3));
    rs2 = 5'($urandom_range(0, 3));
    imm = 12'($urandom);
    u = 20'($urandom);
    f3 = ($urandom_range(0, 4) == 0) ? 3'b001 : 3'b000;
    case ($urandom_range(0, 7))
      0: return {u, rd, 7'b0110111};
      1: return {u, rd, 7'b0010111};
      2: return {imm, rs1, 3'b010, rd, 7'b0000011};
      3: return {imm, rs1, f3, rd, 7'b0010011};
      4: return {imm, rs1, f3, rd, 7'b1100111};
      5: return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
      default: return $urandom;
    endcase
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    in_instr = '0;
    in_pc = '0;
    flush = 1'b0;
    out_ready = 1'b0;
    #3;
    checks++;
    if ({in_ready, out_valid, fuse_flag, fuse_type, out_pc,
         out_instr0, out_instr1, fused_cnt} !==
        {1'b1, 1'b0, 1'b0, 2'b00, 96'd0, 3'd0}) begin
      failures++;
      $display("FAIL reset_state rdy=%b v=%b ff=%b ft=%b pc=%h i0=%h i1=%h cnt=%0d required rdy=1 rest 0",
               in_ready, out_valid, fuse_flag, fuse_type, out_pc,
               out_instr0, out_instr1, fused_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_fuse_pair(input string nm,
                                input logic [31:0] i0,
                                input logic [31:0] i1,
                                input logic [31:0] pc,
                                input logic [1:0] t);
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, i0, pc);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_gather out_valid=%b required 0", nm, out_valid);
    end
    drive(1'b1, i1, pc + 32'd4);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, fuse_flag, fuse_type, out_pc, out_instr0, out_instr1}
        !== {1'b1, 1'b1, t, pc, i0, i1}) begin
      failures++;
      $display("FAIL %s_offer v=%b ff=%b ft=%b pc=%h i0=%h i1=%h required 1 1 %b %h %h %h",
               nm, out_valid, fuse_flag, fuse_type, out_pc, out_instr0,
               out_instr1, t, pc, i0, i1);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready, fused_cnt} !== {1'b0, 1'b1, 3'd1}) begin
      failures++;
      $display("FAIL %s_after v=%b rdy=%b cnt=%0d required v=0 rdy=1 cnt=1",
               nm, out_valid, in_ready, fused_cnt);
    end
  endtask

  task automatic test_rd_mismatch();
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 32'h123452B7, 32'h100);
    drive(1'b1, 32'h00128313, 32'h104);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, fuse_flag, fuse_type, out_pc, out_instr0, out_instr1}
        !== {1'b1, 1'b0, 2'b00, 32'h100, 32'h123452B7, 32'h0}) begin
      failures++;
      $display("FAIL mismatch_first v=%b ff=%b ft=%b pc=%h i0=%h i1=%h required single LUI @100",
               out_valid, fuse_flag, fuse_type, out_pc, out_instr0, out_instr1);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, fuse_flag, fuse_type, out_pc, out_instr0, out_instr1}
        !== {1'b1, 1'b0, 2'b00, 32'h104, 32'h00128313, 32'h0}) begin
      failures++;
      $display("FAIL mismatch_second v=%b ff=%b ft=%b pc=%h i0=%h i1=%h required single ADDI @104",
               out_valid, fuse_flag, fuse_type, out_pc, out_instr0, out_instr1);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, fused_cnt} !== {1'b0, 3'd0}) begin
      failures++;
      $display("FAIL mismatch_end v=%b cnt=%0d required v=0 cnt=0",
               out_valid, fused_cnt);
    end
  endtask

  task automatic test_timeout();
    logic [2:0] seen;
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'h123452B7, 32'h100);
    in_valid = 1'b0;
    seen[0] = out_valid;
    @(negedge clk);
    seen[1] = out_valid;
    @(negedge clk);
    seen[2] = out_valid;
    checks++;
    if (seen !== 3'b100) begin
      failures++;
      $display("FAIL timeout_rise valid(N+1..N+3)=%b required 001 (LSB first)",
               seen);
    end
    drive(1'b1, 32'h67828293, 32'h104);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, in_ready, fuse_flag, fuse_type, out_instr0, out_instr1}
        !== {1'b1, 1'b0, 1'b0, 2'b00, 32'h123452B7, 32'h0}) begin
      failures++;
      $display("FAIL timeout_lock v=%b rdy=%b ff=%b ft=%b i0=%h i1=%h required locked single",
               out_valid, in_ready, fuse_flag, fuse_type, out_instr0, out_instr1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, fuse_flag, out_pc, out_instr0}
        !== {1'b1, 1'b0, 32'h104, 32'h67828293}) begin
      failures++;
      $display("FAIL timeout_addi v=%b ff=%b pc=%h i0=%h required single ADDI @104",
               out_valid, fuse_flag, out_pc, out_instr0);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, fused_cnt} !== {1'b0, 3'd0}) begin
      failures++;
      $display("FAIL timeout_end v=%b cnt=%0d required 0 0", out_valid, fused_cnt);
    end
  endtask

  task automatic test_backpressure_flush();
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'h008303B3, 32'h300);
    checks++;
    if ({in_ready, out_valid} !== 2'b11) begin
      failures++;
      $display("FAIL bp_one rdy=%b v=%b required 1 1", in_ready, out_valid);
    end
    drive(1'b1, 32'h00A303B3, 32'h304);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_full in_ready=%b required 0", in_ready);
    end
    drive(1'b1, 32'h00B303B3, 32'h308);
    checks++;
    if ({in_ready, out_instr0, out_pc} !== {1'b0, 32'h008303B3, 32'h300}) begin
      failures++;
      $display("FAIL bp_held rdy=%b i0=%h pc=%h required 0 008303b3 300",
               in_ready, out_instr0, out_pc);
    end
    flush = 1'b1;
    drive(1'b1, 32'h00C303B3, 32'h30C);
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL flush_clear v=%b rdy=%b required 0 1", out_valid, in_ready);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, fused_cnt} !== {1'b0, 3'd0}) begin
      failures++;
      $display("FAIL flush_drop v=%b cnt=%0d required 0 0", out_valid, fused_cnt);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 32'h123452B7, 32'h100);
    drive(1'b1, 32'h67828293, 32'h104);
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 32'h00000097, 32'h200);
    drive(1'b1, 32'h00008067, 32'h204);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, fuse_type, fused_cnt} !== {1'b1, 2'b10, 3'd1}) begin
      failures++;
      $display("FAIL areset_setup v=%b ft=%b cnt=%0d required 1 10 1",
               out_valid, fuse_type, fused_cnt);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, fuse_flag, fuse_type, out_pc,
         out_instr0, out_instr1, fused_cnt} !==
        {1'b1, 1'b0, 1'b0, 2'b00, 96'd0, 3'd0}) begin
      failures++;
      $display("FAIL areset_now rdy=%b v=%b ff=%b ft=%b pc=%h i0=%h i1=%h cnt=%0d required rdy=1 rest 0",
               in_ready, out_valid, fuse_flag, fuse_type, out_pc,
               out_instr0, out_instr1, fused_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL areset_discard v=%b rdy=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_random();
    logic [31:0] rpc;
    logic [31:0] ev_i0, ev_i1, ev_pc;
    logic [101:0] got, exp;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      ev_i0 = m_commit ? m_win[0][31:0] : 32'h0;
      ev_pc = m_commit ? m_win[0][63:32] : 32'h0;
      ev_i1 = (m_commit && m_dec != 2'b00) ? m_win[1][31:0] : 32'h0;
      got = {in_ready, out_valid, fuse_flag, fuse_type, out_pc,
             out_instr0, out_instr1};
      exp = {m_win.size() < 2, m_commit, m_commit && m_dec != 2'b00,
             m_commit ? m_dec : 2'b00, ev_pc, ev_i0, ev_i1};
      checks++;
      if (got !== exp || int'(fused_cnt) != m_cnt) begin
        failures++;
        $display("FAIL random_cyc%0d got=%h cnt=%0d required=%h cnt=%0d",
                 c, got, fused_cnt, exp, m_cnt);
      end
      rpc = $urandom;
      in_valid = ($urandom_range(0, 9) < 7);
      in_instr = gen_instr();
      in_pc = ($urandom_range(0, 9) != 0) ? m_last_pc + 32'd4
                                          : {rpc[31:2], 2'b00};
      out_ready = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 49) == 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_fuse_pair("lui_addi", 32'h123452B7, 32'h67828293, 32'h100, 2'b01);
    test_fuse_pair("auipc_jalr", 32'h00000097, 32'h00008067, 32'h200, 2'b10);
    test_fuse_pair("load_alu", 32'h00052303, 32'h008303B3, 32'h400, 2'b11);
    test_rd_mismatch();
    test_timeout();
    test_backpressure_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
